// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: opcode map and FSM state type shared by the multi-cycle ALU.
// Optional iterative mul/divu/remu is enabled by defining MC_ALU_MULDIV_EN.
package mc_alu_pkg;

    // Opcode map; 00000-01011 are inherited from the single-cycle ALU.
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ZERO = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOR  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_SLT  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REMU = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the opcodes that need the iterative datapath.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mc_alu_muldiv.sv
// mc_alu_muldiv: shared iterative datapath, one shift-add (multiply) or one
// restoring-divide step per 'step' cycle. Registers are reused by both modes:
//   acc : product accumulator / partial remainder
//   b   : shifted multiplicand / dividend shifting into quotient
//   c   : multiplier shifting right / divisor (constant)
// Outputs carry the post-step values and are only meaningful when 'last'.
// Only instantiated when MC_ALU_MULDIV_EN is defined.
module mc_alu_muldiv
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             last,
    input  logic             is_div,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] prod,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             mode_q, mode_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            c_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            c_q    <= c_d;
            mode_q <= mode_d;
        end
    end

    // Load on start, otherwise advance one iteration per step.
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        c_d    = c_q;
        mode_d = mode_q;
        trial  = {acc_q, b_q[WIDTH-1]};
        diff   = trial - {1'b0, c_q};
        if (start) begin
            acc_d  = '0;
            b_d    = in1;
            c_d    = in2;
            mode_d = is_div;
        end else if (step) begin
            if (mode_q) begin
                // Restoring divide: shift next dividend bit into remainder.
                if (trial >= {1'b0, c_q}) begin
                    acc_d = diff[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = trial[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Shift-add multiply, low WIDTH bits only.
                if (c_q[0]) begin
                    acc_d = acc_q + b_q;
                end
                b_d = b_q << 1;
                c_d = c_q >> 1;
            end
        end
    end

    // Results are presented only on the final step.
    always_comb begin
        prod = last ? acc_d : '0;
        quo  = last ? b_d   : '0;
        rem  = last ? acc_d : '0;
    end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with registered valid/ready handshake.
// Handshake: an op is accepted on a rising edge where in_valid && in_ready
// (in_ready only in IDLE); a result is consumed on a rising edge where
// out_valid && out_ready, and result/div_by_zero are held until then.
// Define MC_ALU_MULDIV_EN to build iterative mul/divu/remu; otherwise those
// opcodes finish in one cycle with result 0.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] single_res;
    logic [SHW-1:0]   sh;

    // Single-cycle ops, evaluated directly on the offered operands.
    always_comb begin
        sh = in1[SHW-1:0];
        case (alu_op)
            OP_ADD:  single_res = in1 + in2;
            OP_SUB:  single_res = in1 - in2;
            OP_AND:  single_res = in1 & in2;
            OP_OR:   single_res = in1 | in2;
            OP_XOR:  single_res = in1 ^ in2;
            OP_NOR:  single_res = ~in1 & ~in2;
            OP_SLL:  single_res = in2 << sh;
            OP_SRL:  single_res = in2 >> sh;
            OP_SRA:  single_res = $signed(in2) >>> sh;
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default: single_res = '0;
        endcase
    end

`ifdef MC_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [4:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic             md_start, md_step, md_last;
    logic [WIDTH-1:0] md_prod, md_quo, md_rem;

    mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .step   (md_step),
        .last   (md_last),
        .is_div (alu_op != OP_MUL),
        .in1    (in1),
        .in2    (in2),
        .prod   (md_prod),
        .quo    (md_quo),
        .rem    (md_rem)
    );

    // Opcode and iteration counter for the long ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_ADD;
            count_q <= '0;
        end else begin
            op_q    <= op_d;
            count_q <= count_d;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dbz_d    = dbz_q;
`ifdef MC_ALU_MULDIV_EN
        op_d     = op_q;
        count_d  = count_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        md_last  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef MC_ALU_MULDIV_EN
                    op_d = alu_op;
                    if (is_muldiv(alu_op)) begin
                        if (alu_op != OP_MUL && in2 == '0) begin
                            // Divide by zero: no iteration.
                            result_d = (alu_op == OP_DIVU) ? '1 : in1;
                            dbz_d    = 1'b1;
                            state_d  = DONE;
                        end else begin
                            md_start = 1'b1;
                            count_d  = CW'(WIDTH);
                            state_d  = BUSY;
                        end
                    end else begin
                        result_d = single_res;
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end
`else
                    result_d = single_res;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
`endif
                end
            end
`ifdef MC_ALU_MULDIV_EN
            BUSY: begin
                md_step = 1'b1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    md_last = 1'b1;
                    dbz_d   = 1'b0;
                    case (op_q)
                        OP_MUL:  result_d = md_prod;
                        OP_DIVU: result_d = md_quo;
                        default: result_d = md_rem;
                    endcase
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of registered state.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        result      = result_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed, table-driven bench for mc_alu at WIDTH=32.
// Expectations for mul/divu/remu follow whether MC_ALU_MULDIV_EN is defined.
module tb_mc_alu;
    import mc_alu_pkg::*;

    localparam int W = 32;
`ifdef MC_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int LONG = MD ? W + 1 : 1;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   alu_op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         div_by_zero;

    int errors;
    int checks;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_dbz;
        int           exp_lat;
        string        name;
    } vec_t;

    vec_t vecs[$];

    mc_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one op (waiting for in_ready), then scramble inputs after accept.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        alu_op   = op;
        in1      = a;
        in2      = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        alu_op   = 5'($urandom_range(0, 31));
        in1      = $urandom;
        in2      = $urandom;
    endtask

    // Called at the first negedge after accept; counts cycles to out_valid.
    task automatic wait_valid(output int lat, output bit ready_seen);
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit ready_seen;
        out_ready = 1'b0;
        issue(v.op, v.a, v.b);
        wait_valid(lat, ready_seen);
        chk({v.name, "/out_valid"}, 64'(out_valid), 64'd1);
        chk({v.name, "/latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, "/result"}, 64'(result), 64'(v.exp_res));
        chk({v.name, "/dbz"}, 64'(div_by_zero), 64'(v.exp_dbz));
        chk({v.name, "/busy_ready"}, 64'(ready_seen), 64'd0);
        chk({v.name, "/done_ready"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, "/ready_back"}, 64'(in_ready), 64'd1);
        chk({v.name, "/valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic z, input int lat, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_dbz = z; v.exp_lat = lat; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        bit ready_seen;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        in1       = '0;
        in2       = '0;

        // Vector table: hand-computed expectations.
        add_vec(OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1, "add");
        add_vec(OP_ADD,  32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 1, "add_wrap");
        add_vec(OP_ZERO, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b0, 1, "zero");
        add_vec(OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1, "sub_wrap");
        add_vec(OP_AND,  32'hF0F0_FF00,  32'hFF00_0FF0,  32'hF000_0F00,  1'b0, 1, "and");
        add_vec(OP_OR,   32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  1'b0, 1, "or");
        add_vec(OP_XOR,  32'hFFFF_0000,  32'hF0F0_F0F0,  32'h0F0F_F0F0,  1'b0, 1, "xor");
        add_vec(OP_NOR,  32'hFFFF_0000,  32'h00FF_00F0,  32'h0000_FF0F,  1'b0, 1, "nor");
        add_vec(OP_SLL,  32'hFFFF_FFE4,  32'h0000_0001,  32'h0000_0010,  1'b0, 1, "sll_hi_ignored");
        add_vec(OP_SRL,  32'd4,          32'h8000_0000,  32'h0800_0000,  1'b0, 1, "srl");
        add_vec(OP_SRA,  32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0, 1, "sra");
        add_vec(OP_SRA,  32'd31,         32'h4000_0000,  32'h0000_0000,  1'b0, 1, "sra_pos");
        add_vec(OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1, "slt");
        add_vec(OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1, "sltu");
        add_vec(OP_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1, "sltu_true");
        add_vec(5'b11111, 32'd9,         32'd9,          32'd0,          1'b0, 1, "unlisted");
        add_vec(OP_MUL,  32'h0001_0003,  32'h0002_0005,  MD ? 32'h000B_000F : 32'd0, 1'b0, LONG, "mul");
        add_vec(OP_MUL,  32'd3,          32'd5,          MD ? 32'd15 : 32'd0,         1'b0, LONG, "mul_3x5");
        add_vec(OP_DIVU, 32'd100,        32'd7,          MD ? 32'd14 : 32'd0,         1'b0, LONG, "divu");
        add_vec(OP_REMU, 32'd100,        32'd7,          MD ? 32'd2 : 32'd0,          1'b0, LONG, "remu");
        add_vec(OP_DIVU, 32'hFFFF_FFFF,  32'h10,         MD ? 32'h0FFF_FFFF : 32'd0,  1'b0, LONG, "divu_big");
        add_vec(OP_REMU, 32'd7,          32'd100,        MD ? 32'd7 : 32'd0,          1'b0, LONG, "remu_small");
        add_vec(OP_DIVU, 32'd5,          32'd0,          MD ? 32'hFFFF_FFFF : 32'd0,  MD, 1, "divu_by0");
        add_vec(OP_REMU, 32'd5,          32'd0,          MD ? 32'd5 : 32'd0,          MD, 1, "remu_by0");
        add_vec(OP_ADD,  32'd1,          32'd1,          32'd2,          1'b0, 1, "add_after_dbz");

        // Reset values.
        do_reset();
        chk("rst/in_ready", 64'(in_ready), 64'd1);
        chk("rst/out_valid", 64'(out_valid), 64'd0);
        chk("rst/result", 64'(result), 64'd0);
        chk("rst/dbz", 64'(div_by_zero), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stall in DONE for 10 cycles with competing in_valid traffic.
        out_ready = 1'b0;
        issue(OP_ADD, 32'd40, 32'd2);
        wait_valid(lat, ready_seen);
        chk("stall/first_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            alu_op   = OP_SUB;
            in1      = $urandom;
            in2      = $urandom;
            @(negedge clk);
            chk($sformatf("stall/valid_%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("stall/result_%0d", k), 64'(result), 64'd42);
            chk($sformatf("stall/ready_%0d", k), 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall/ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("stall/no_ghost_op", 64'(out_valid), 64'd0);
        chk("stall/result_kept", 64'(result), 64'd42);

        // Reset 10 cycles into a mul (in DONE when the iterative unit is absent).
        issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort/out_valid", 64'(out_valid), 64'd0);
        chk("abort/result", 64'(result), 64'd0);
        chk("abort/in_ready", 64'(in_ready), 64'd1);
        chk("abort/dbz", 64'(div_by_zero), 64'd0);
        repeat (40) @(negedge clk);
        chk("abort/stays_idle", 64'(out_valid), 64'd0);

        // Back-to-back throughput: accept, consume, re-accept at one op per 2 cycles.
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; alu_op = OP_XOR; in1 = 32'hA; in2 = 32'h5;
        @(negedge clk);
        chk("tput/valid_1", 64'(out_valid), 64'd1);
        chk("tput/result_1", 64'(result), 64'hF);
        alu_op = OP_OR; in1 = 32'h30; in2 = 32'h0C;
        @(negedge clk);
        chk("tput/ready_2", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("tput/valid_2", 64'(out_valid), 64'd1);
        chk("tput/result_2", 64'(result), 64'h3C);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
# mc_alu

Multi-cycle, width-parametrised ALU that succeeds the single-cycle 5-bit-opcode ALU in the pipeline's execute stage. It keeps the existing opcode map and semantics and adds iterative unsigned multiply, divide and remainder. Every operation runs behind a registered valid/ready handshake, so the execute stage can stall on long operations. One operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept; high only in IDLE.
- alu_op  input  5  opcode, sampled on accept.
- in1  input  WIDTH  operand 1; shift amount for shift ops.
- in2  input  WIDTH  operand 2; value shifted for shift ops.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- div_by_zero  output  1  flag qualified by out_valid.

## Operation
- Opcodes (unchanged):
  - 00000 add; 00001 zero; 00010 sub; 00011 and; 00100 or; 00101 xor; 00110 nor (~in1 & ~in2).
  - 00111 sll (in2 << sh); 01000 srl (in2 >> sh); 01001 sra (in2 >>> sh).
  - 01010 sltu → 1/0; 01011 slt signed → 1/0.
- Opcodes (new): 01100 mul (low WIDTH bits of unsigned product); 01101 divu (quotient); 01110 remu (remainder).
- Unlisted opcodes produce result 0.
- Shift amount sh = in1[$clog2(WIDTH)-1:0]; upper bits of in1 are ignored, so there is no shift-by-≥WIDTH case.
- add, sub and mul wrap modulo 2^WIDTH; there is no carry or overflow output.
- FSM:
  - IDLE: in_ready=1. On accept, latch op and operands. Single-cycle ops go to DONE; mul/divu/remu go to BUSY with count=WIDTH.
  - BUSY: one shift-add (mul) or one restoring-divide step (div) per cycle; count decrements; at count==1 go to DONE with the result registered.
  - DONE: out_valid=1; result and div_by_zero held stable until out_ready=1, then go to IDLE.
- Divide by zero: no iteration. Go IDLE→DONE directly; divu returns all ones, remu returns in1, div_by_zero=1.
- div_by_zero is 0 for every other opcode.

## Timing
- Reset values: in_ready=1 the cycle after reset; out_valid=0, result=0, div_by_zero=0; state IDLE; counter 0.
- Reset mid-BUSY or in DONE aborts the operation and discards the result.
- Single-cycle ops: out_valid rises 1 cycle after the accept edge.
- mul/divu/remu: out_valid rises WIDTH+1 cycles after accept (33 at WIDTH=32). Divide-by-zero: 1 cycle.
- The handshake from DONE back to IDLE costs one cycle, so in_ready is low in the DONE cycle in which out_ready is sampled. Peak throughput is one op per 2 cycles.
- in_valid and operands may change freely while in_ready=0; they are ignored.
- out_valid is never withdrawn before out_ready is seen high.

## Configuration
- MC_ALU_MULDIV_EN defined: mul/divu/remu are implemented as above.
- MC_ALU_MULDIV_EN undefined:
  - Iterative datapath and counter are removed; opcodes 01100–01110 complete as single-cycle ops with result 0 and div_by_zero=0.
  - BUSY is unreachable and need not be synthesised.

## Structure
- Package mc_alu_pkg: opcode localparams (OP_ADD … OP_REMU), state enum (IDLE, BUSY, DONE).
- Sub-module mc_alu_muldiv (parameter WIDTH): shared iterative shift-add / restoring-divide datapath with start, step and last controls from the parent FSM. It is instantiated only under MC_ALU_MULDIV_EN.
- Parent mc_alu holds the FSM, handshake registers and single-cycle ops.

## Test plan
- WIDTH=32, op sra, in1=4, in2=0x8000_0000, out_ready=1 → out_valid 1 cycle after accept, result 0xF800_0000; in_ready back high 1 cycle later.
- op slt, in1=0xFFFF_FFFF, in2=1 → result 1; op sltu, same operands → result 0.
- op mul, in1=0x0001_0003, in2=0x0002_0005 → out_valid exactly 33 cycles after accept, result 0x000B_000F; in_ready=0 throughout.
- op divu 100/7 → result 14; op remu 100/7 → result 2; op divu 5/0 → result 0xFFFF_FFFF, div_by_zero=1, latency 1.
- Hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, new in_valid ignored. Separately, assert reset at cycle 10 of a mul → next cycle out_valid=0, result=0, in_ready=1.
- Build without MC_ALU_MULDIV_EN, op mul 3×5 → result 0 after 1 cycle, div_by_zero=0.
